// File: rtl/xadc_avg_pkg.sv
// Shared types and width helpers for the multi-channel XADC sliding-window averager.
package xadc_avg_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    READ   = 2'd1,
    UPDATE = 2'd2,
    OUT    = 2'd3
  } avg_state_e;

  // Running sum must hold W*(2^N-1) for the largest window
  function automatic int unsigned sum_width(input int unsigned n, input int unsigned max_power);
    return n + max_power;
  endfunction

  // Fill count must reach 2^MAX_POWER inclusive
  function automatic int unsigned cnt_width(input int unsigned max_power);
    return max_power + 1;
  endfunction

  function automatic int unsigned k_eff(input int unsigned sel, input int unsigned max_power);
    return (sel > max_power) ? max_power : sel;
  endfunction

endpackage

// File: rtl/xadc_avg_ram.sv
// Simple dual-port sample store: one write port, one synchronous read port, no reset.
module xadc_avg_ram #(
  parameter int unsigned DW    = 12,
  parameter int unsigned AW    = 6,
  parameter int unsigned DEPTH = 64
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [DW-1:0] i_wdata,
  input  logic [AW-1:0] i_raddr,
  output logic [DW-1:0] o_rdata
);

  logic [DW-1:0] r_mem [DEPTH];
  logic [DW-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/xadc_multich_averager.sv
// Per-channel power-of-two sliding-window average of time-multiplexed XADC samples,
// with all channel histories kept in one shared circular-buffer RAM.
module xadc_multich_averager
  import xadc_avg_pkg::*;
#(
  parameter int unsigned N         = 12,
  parameter int unsigned MAX_POWER = 8,
  parameter int unsigned NUM_CH    = 4,
  parameter int unsigned CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  parameter int unsigned SEL_W     = $clog2(MAX_POWER + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CH_W-1:0]  in_ch,
  input  logic [N-1:0]     in_data,
  input  logic [SEL_W-1:0] win_sel,
  input  logic             flush,
  output logic             out_valid,
  output logic [CH_W-1:0]  out_ch,
  output logic [N-1:0]     out_data,
  output logic             out_full
);

  localparam int unsigned SUM_W  = sum_width(N, MAX_POWER);
  localparam int unsigned CNT_W  = cnt_width(MAX_POWER);
  localparam int unsigned AW     = CH_W + MAX_POWER;
  localparam int unsigned DEPTH  = NUM_CH << MAX_POWER;
  localparam int unsigned CH_SPC = 1 << CH_W;

  avg_state_e r_state;
  logic [CH_W-1:0]  r_ch;
  logic [N-1:0]     r_din;
  logic [SEL_W-1:0] r_win_sel;
  logic             r_sel_valid;

  logic [MAX_POWER-1:0] r_ptr [NUM_CH];
  logic [SUM_W-1:0]     r_sum [NUM_CH];
  logic [CNT_W-1:0]     r_cnt [NUM_CH];

  logic [SEL_W-1:0]     w_k;
  logic [CNT_W-1:0]     w_win;
  logic [MAX_POWER-1:0] w_ptr_cur;
  logic [SUM_W-1:0]     w_sum_cur;
  logic [CNT_W-1:0]     w_cnt_cur;
  logic [SUM_W-1:0]     w_old;
  logic [SUM_W-1:0]     w_sum_new;
  logic [CNT_W-1:0]     w_cnt_new;
  logic [AW-1:0]        w_rd_addr;
  logic [AW-1:0]        w_wr_addr;
  logic [N-1:0]         w_rd_data;
  logic                 w_we;
  logic                 w_win_change;
  logic                 w_clear;
  logic                 w_accept;
  logic [CH_SPC-1:0]    w_ch_ok_vec;
  logic                 w_ch_ok;

  // Channel codes at or above NUM_CH are accepted but discarded
  for (genvar g = 0; g < CH_SPC; g++) begin : g_ch_ok
    assign w_ch_ok_vec[g] = (g < NUM_CH);
  end
  assign w_ch_ok = w_ch_ok_vec[in_ch];

  // The first cycle after reset only captures win_sel, so it is never seen as a change
  assign w_win_change = r_sel_valid && (win_sel != r_win_sel);
  assign w_clear      = flush || w_win_change;
  assign in_ready     = (r_state == IDLE) && !w_clear;
  assign w_accept     = in_valid && in_ready && w_ch_ok;

  assign w_k       = SEL_W'(k_eff(32'(r_win_sel), MAX_POWER));
  assign w_win     = CNT_W'(1) << w_k;
  assign w_ptr_cur = r_ptr[r_ch];
  assign w_sum_cur = r_sum[r_ch];
  assign w_cnt_cur = r_cnt[r_ch];

  // Oldest sample in the window sits W slots behind the write pointer
  assign w_rd_addr = {r_ch, w_ptr_cur - MAX_POWER'(w_win)};
  assign w_wr_addr = {r_ch, w_ptr_cur};
  assign w_we      = (r_state == UPDATE) && !w_clear;

  assign w_old     = (w_cnt_cur >= w_win) ? SUM_W'(w_rd_data) : '0;
  assign w_sum_new = w_sum_cur + SUM_W'(r_din) - w_old;
  assign w_cnt_new = (w_cnt_cur >= w_win) ? w_win : w_cnt_cur + CNT_W'(1);

  xadc_avg_ram #(
    .DW    (N),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (w_wr_addr),
    .i_wdata (r_din),
    .i_raddr (w_rd_addr),
    .o_rdata (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win_sel   <= '0;
      r_sel_valid <= 1'b0;
    end else begin
      r_win_sel   <= win_sel;
      r_sel_valid <= 1'b1;
    end
  end

  // Per-channel pointer, running sum and fill count
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_ptr[i] <= '0;
        r_sum[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (w_clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_ptr[i] <= '0;
        r_sum[i] <= '0;
        r_cnt[i] <= '0;
      end
    end else if (r_state == UPDATE) begin
      r_ptr[r_ch] <= w_ptr_cur + MAX_POWER'(1);
      r_sum[r_ch] <= w_sum_new;
      r_cnt[r_ch] <= w_cnt_new;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_ch      <= '0;
      r_din     <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
      out_data  <= '0;
      out_full  <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (w_clear) begin
        r_state <= IDLE;
      end else begin
        case (r_state)
          IDLE: begin
            if (w_accept) begin
              r_ch    <= in_ch;
              r_din   <= in_data;
              r_state <= READ;
            end
          end
          READ:   r_state <= UPDATE;
          UPDATE: begin
            r_state   <= OUT;
            out_valid <= 1'b1;
            out_ch    <= r_ch;
            out_data  <= N'(w_sum_new >> w_k);
            out_full  <= (w_cnt_new >= w_win);
          end
          OUT:     r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_xadc_multich_averager.sv
// Directed, table-driven bench for xadc_multich_averager (N=12, MAX_POWER=4, NUM_CH=4).
module tb_xadc_multich_averager;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_ch;
  logic [11:0] in_data;
  logic [2:0]  win_sel;
  logic        flush;
  logic        out_valid;
  logic [1:0]  out_ch;
  logic [11:0] out_data;
  logic        out_full;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [1:0]  ch;
    logic [11:0] din;
    logic [2:0]  sel;
    logic [11:0] exp_data;
    logic        exp_full;
  } vec_t;

  vec_t tbl [57];

  xadc_multich_averager #(
    .N         (12),
    .MAX_POWER (4),
    .NUM_CH    (4)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_ch     (in_ch),
    .in_data   (in_data),
    .win_sel   (win_sel),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .out_data  (out_data),
    .out_full  (out_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  // Called at a negedge; waits for ready, transfers one sample and checks its result
  task automatic send(input logic [1:0] ch, input logic [11:0] d,
                      input logic [11:0] ed, input logic ef, input string name);
    int n;
    bit seen;
    #1;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!in_ready) begin
      check({name, " ready_timeout"}, 0, 1);
      return;
    end
    in_valid = 1'b1;
    in_ch    = ch;
    in_data  = d;
    @(posedge clk);
    n    = 0;
    seen = 1'b0;
    while (n < 8 && !seen) begin
      @(negedge clk);
      n++;
      if (n == 1) in_valid = 1'b0;
      if (out_valid) seen = 1'b1;
    end
    check({name, " out_valid_seen"}, int'(seen), 1);
    if (seen) begin
      check({name, " latency"}, n, 3);
      check({name, " out_data"}, int'(out_data), int'(ed));
      check({name, " out_full"}, int'(out_full), int'(ef));
      check({name, " out_ch"}, int'(out_ch), int'(ch));
    end
  endtask

  task automatic run_vecs(input int lo, input int hi, input string name);
    for (int i = lo; i <= hi; i++) begin
      if (win_sel != tbl[i].sel) win_sel = tbl[i].sel;
      send(tbl[i].ch, tbl[i].din, tbl[i].exp_data, tbl[i].exp_full,
           $sformatf("%s[%0d]", name, i - lo));
    end
  endtask

  initial begin
    int idx;
    int outs;
    bit prev_rdy;
    bit seen;
    logic [11:0] cont_exp [4];

    // Test 1: W=4 ramp then steady state on ch0
    tbl[0] = '{2'd0, 12'd100, 3'd2, 12'd25,  1'b0};
    tbl[1] = '{2'd0, 12'd200, 3'd2, 12'd75,  1'b0};
    tbl[2] = '{2'd0, 12'd300, 3'd2, 12'd150, 1'b0};
    tbl[3] = '{2'd0, 12'd400, 3'd2, 12'd250, 1'b1};
    tbl[4] = '{2'd0, 12'd500, 3'd2, 12'd350, 1'b1};
    // Test 2: W=16, ch1 full-scale interleaved with ch2 zero
    idx = 5;
    for (int k = 1; k <= 16; k++) begin
      tbl[idx] = '{2'd1, 12'd4095, 3'd4, 12'((4095 * k) / 16), (k >= 16)};
      idx++;
      tbl[idx] = '{2'd2, 12'd0, 3'd4, 12'd0, (k >= 16)};
      idx++;
    end
    // Test 6: win_sel=7 clamps to W=16, pointer wraps after 16 samples
    for (int k = 1; k <= 20; k++) begin
      tbl[idx] = '{2'd0, 12'd160, 3'd7, 12'((k >= 16) ? 160 : 10 * k), (k >= 16)};
      idx++;
    end
    cont_exp[0] = 12'd2;
    cont_exp[1] = 12'd6;
    cont_exp[2] = 12'd12;
    cont_exp[3] = 12'd20;

    reset    = 1'b0;
    in_valid = 1'b0;
    in_ch    = 2'd0;
    in_data  = 12'd0;
    win_sel  = 3'd2;
    flush    = 1'b0;
    repeat (3) @(negedge clk);
    check("reset out_valid", int'(out_valid), 0);
    check("reset out_data", int'(out_data), 0);
    check("reset out_full", int'(out_full), 0);
    check("reset out_ch", int'(out_ch), 0);
    reset = 1'b1;
    #1;
    check("post-reset in_ready", int'(in_ready), 1);

    run_vecs(0, 4, "t1");

    // Test 3: window change stalls one cycle and clears state
    @(negedge clk);
    win_sel = 3'd3;
    #1;
    check("t3 in_ready during change", int'(in_ready), 0);
    @(negedge clk);
    #1;
    check("t3 in_ready after clear", int'(in_ready), 1);
    send(2'd0, 12'd80, 12'd10, 1'b0, "t3");

    run_vecs(5, 36, "t2");

    // Test 4: flush during UPDATE aborts the sample
    win_sel = 3'd2;
    #1;
    idx = 0;
    while (!in_ready && idx < 20) begin
      @(negedge clk);
      #1;
      idx++;
    end
    check("t4 ready before flush", int'(in_ready), 1);
    in_valid = 1'b1;
    in_ch    = 2'd0;
    in_data  = 12'd999;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    flush = 1'b1;
    seen  = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      flush = 1'b0;
      if (out_valid) seen = 1'b1;
    end
    check("t4 aborted out_valid", int'(seen), 0);
    send(2'd0, 12'd64, 12'd16, 1'b0, "t4");

    // Test 5a: in_valid held high, one transfer every 4 clocks on ch3
    @(negedge clk);
    in_valid = 1'b1;
    in_ch    = 2'd3;
    in_data  = 12'd8;
    outs     = 0;
    #1;
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t5 in_ready cyc%0d", i), int'(in_ready), int'(i % 4 == 0));
      check($sformatf("t5 out_valid cyc%0d", i), int'(out_valid), int'(i >= 3 && (i - 3) % 4 == 0));
      if (out_valid && outs < 4) begin
        check($sformatf("t5 out_data #%0d", outs), int'(out_data), int'(cont_exp[outs]));
        check($sformatf("t5 out_ch #%0d", outs), int'(out_ch), 3);
        outs++;
      end
      prev_rdy = in_ready;
      if (i < 15) begin
        @(negedge clk);
        if (prev_rdy) in_data = in_data + 12'd8;
        #1;
      end
    end
    in_valid = 1'b0;
    check("t5 outputs counted", outs, 4);

    // Test 5b: asynchronous reset in the middle of OUT
    @(negedge clk);
    #1;
    in_valid = 1'b1;
    in_ch    = 2'd3;
    in_data  = 12'd100;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5b out_valid in OUT", int'(out_valid), 1);
    #2;
    reset = 1'b0;
    #1;
    check("t5b async out_valid", int'(out_valid), 0);
    check("t5b async out_data", int'(out_data), 0);
    check("t5b async out_full", int'(out_full), 0);
    check("t5b async out_ch", int'(out_ch), 0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("t5b in_ready after release", int'(in_ready), 1);
    send(2'd3, 12'd40, 12'd10, 1'b0, "t5b");

    run_vecs(37, 56, "t6");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/xadc_multich_averager.md
Name: xadc_multich_averager

Overview:
Parametrised successor to the single-channel moving-average filter. Averages time-multiplexed XADC samples over a per-channel sliding window whose length is selectable at run time as a power of two. Samples are held in one circular-buffer RAM shared by all channels, not in a shift register. Sits between the XADC sequencer/DRP reader and the display and scaling logic, with a valid/ready input and a channel-tagged valid output.

Parameters:
N, 12, sample width in bits.
MAX_POWER, 8, largest window exponent; maximum window = 2^MAX_POWER samples.
NUM_CH, 4, number of channels, at least 1.
CH_W, $clog2(NUM_CH) (minimum 1), derived; do not override.
SEL_W, $clog2(MAX_POWER+1), derived; do not override.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-low reset.
in_valid  in  1  sample present.
in_ready  out  1  block can accept a sample.
in_ch  in  CH_W  channel of the sample.
in_data  in  N  unsigned sample.
win_sel  in  SEL_W  window exponent k; window W = 2^min(k,MAX_POWER).
flush  in  1  synchronous clear of all channel state.
out_valid  out  1  one-cycle pulse; the result is valid.
out_ch  out  CH_W  channel of the result.
out_data  out  N  window average.
out_full  out  1  the channel's window has filled since the last clear.

Behaviour:
- Per-channel state: write pointer (MAX_POWER bits), running sum (MAX_POWER+N bits), fill count (MAX_POWER+1 bits, saturates at W).
- Sample RAM has NUM_CH*2^MAX_POWER words of N bits, addressed {ch, ptr}. It has synchronous read and write, and its contents are never cleared.
- FSM states: IDLE, READ, UPDATE, OUT.
  - IDLE: in_ready = 1 when flush = 0 and there is no pending window change.
  - Transfer on in_valid && in_ready at edge T0. Register ch and data, then go to READ.
  - READ (cycle after T0): present RAM read address {ch, ptr[ch] - W} (modulo 2^MAX_POWER). Go to UPDATE.
  - UPDATE: old = (count[ch] >= W) ? RAM data : 0. sum_new = sum[ch] + din - old. Write din at {ch, ptr[ch]}. ptr[ch] increments and wraps at 2^MAX_POWER. count[ch] increments and saturates at W. Go to OUT.
  - OUT: out_valid = 1 for exactly this cycle. out_data = sum_new >> k_eff (truncate, no rounding). out_full = count_new >= W. Then go to IDLE.
- Latency: out_valid is asserted in the third cycle after the transfer edge (T0+3). Throughput is 1 sample per 4 clocks. in_ready = 0 in READ, UPDATE and OUT.
- outputs hold their last values when out_valid = 0.
- Fill behaviour: before the window fills, the missing samples count as 0, so the output ramps up from zero.
- Sum never overflows: W*(2^N-1) < 2^(MAX_POWER+N).
- win_sel is registered each cycle. A change from the registered value, or flush = 1, has these effects:
  - In the next cycle, all sums, counts and pointers clear to 0.
  - Any in-flight sample is aborted: the FSM returns to IDLE and out_valid is not pulsed.
  - in_ready = 0 during the clear cycle.
- flush has priority over in_valid in the same cycle.
- in_ch >= NUM_CH (NUM_CH not a power of two): the sample is accepted and dropped, with no state change and no out_valid.
- win_sel > MAX_POWER is clamped to MAX_POWER.
- Asserting reset (low) immediately forces the following, regardless of clk:
  - FSM = IDLE;
  - all per-channel state = 0;
  - out_valid = 0, out_ch = 0, out_data = 0, out_full = 0;
  - in_ready = 1 once released.

Decomposition:
- Package xadc_avg_pkg holds:
  - state enum typedef (IDLE, READ, UPDATE, OUT);
  - helper function for the clamped exponent k_eff;
  - localparam width expressions for the sum and count.
- One sub-module, xadc_avg_ram: simple dual-port, synchronous read, inferable as BRAM, no reset on its storage.

Test Plan:
- Bench parameters: N=12, MAX_POWER=4, NUM_CH=4.
1. Reset released; win_sel=2; ch0 samples 100, 200, 300, 400, 500 -> out_data 25, 75, 150, 250, 350; out_full 0, 0, 0, 1, 1; out_ch=0.
2. win_sel=4; ch1 = 4095 and ch2 = 0 interleaved, 16 samples each -> ch1 k-th output = floor(4095k/16), ending at 4095 with out_full=1 on the 16th; ch2 always 0 (no crosstalk).
3. After test 1, change win_sel 2->3 -> in_ready low one cycle, state cleared; next ch0 sample 80 -> out_data 10, out_full 0.
4. flush pulsed during UPDATE of an accepted ch0 sample -> no out_valid for it; next ch0 sample 64 with win_sel=2 -> out_data 16.
5. in_valid held high continuously -> in_ready high 1 of every 4 cycles, each sample consumed once, out_valid exactly 3 cycles after each transfer. reset pulsed low between edges mid-OUT -> out_valid falls immediately; after release, ch3 sample 40 with W=4 -> 10.
6. win_sel=7 (clamped to 4); 20 ch0 samples of value 160 -> outputs ramp 10, 20, … 160, out_full rises on the 16th sample and 160 holds afterwards (wrap of pointer verified).
